// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the instruction and data caches access to a
// single-port line memory with a fixed access latency.
module mem_arbiter #(
  parameter int cache_line_width = 256,
  parameter int addr_width       = 16,
  parameter int mem_latency      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iPetition,
  input  logic [addr_width-1:0]       iAddr,
  output logic                        iServiceReady,
  input  logic                        dPetition,
  input  logic [addr_width-1:0]       dAddr,
  input  logic                        dWe,
  input  logic [cache_line_width-1:0] dWriteData,
  output logic                        dServiceReady,
  output logic [cache_line_width-1:0] dataReadFromMem,
  output logic [addr_width-1:0]       memAddr,
  output logic                        memWe,
  output logic [cache_line_width-1:0] memWriteData,
  input  logic [cache_line_width-1:0] memReadData,
  output logic                        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic [7:0] COUNT_LOAD = 8'(mem_latency - 1);

  logic [1:0]                  state;
  logic [7:0]                  count;
  logic                        last_served;
  logic                        owner;
  logic                        we_q;
  logic [addr_width-1:0]       addr_q;
  logic [cache_line_width-1:0] wdata_q;

  logic                        grant_i;
  logic                        grant_d;
  logic [addr_width-1:0]       i_line_addr;
  logic [addr_width-1:0]       d_line_addr;

  // On a tie the requester not served last wins; reset leaves D as last served.
  always_comb begin
    grant_i = iPetition && (!dPetition || (last_served == OWNER_D));
    grant_d = dPetition && !grant_i;
  end

  assign i_line_addr = {iAddr[addr_width-1:4], 4'b0000};
  assign d_line_addr = {dAddr[addr_width-1:4], 4'b0000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      last_served <= OWNER_D;
      owner       <= OWNER_I;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state       <= BUSY;
            count       <= COUNT_LOAD;
            owner       <= grant_d;
            last_served <= grant_d;
            addr_q      <= grant_d ? d_line_addr : i_line_addr;
            we_q        <= grant_d && dWe;
            wdata_q     <= dWriteData;
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            state <= RESP;
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign busy            = (state != IDLE);
  assign iServiceReady   = (state == RESP) && (owner == OWNER_I);
  assign dServiceReady   = (state == RESP) && (owner == OWNER_D);
  assign memWe           = (state == RESP) && we_q;
  assign memAddr         = addr_q;
  assign memWriteData    = wdata_q;
  assign dataReadFromMem = memReadData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural line memory.
module tb_mem_arbiter;

  localparam int LW  = 256;
  localparam int AW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          iPetition, dPetition, dWe;
  logic [AW-1:0] iAddr, dAddr;
  logic [LW-1:0] dWriteData;
  logic          iServiceReady, dServiceReady, memWe, busy;
  logic [LW-1:0] dataReadFromMem, memWriteData, memReadData;
  logic [AW-1:0] memAddr;

  // second instance with latency 1
  logic          i2Petition;
  logic [AW-1:0] i2Addr;
  logic          d2Petition = 1'b0, d2We = 1'b0;
  logic [AW-1:0] d2Addr = '0;
  logic [LW-1:0] d2WriteData = '0;
  logic          i2ServiceReady, d2ServiceReady, mem2We, busy2;
  logic [LW-1:0] data2ReadFromMem, mem2WriteData, mem2ReadData;
  logic [AW-1:0] mem2Addr;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] mem      [0:4095];
  bit            wr_valid [0:4095];

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {8{a, ~a}};
  endfunction

  assign memReadData  = wr_valid[memAddr[15:4]] ? mem[memAddr[15:4]]
                                                : init_line({memAddr[15:4], 4'b0000});
  assign mem2ReadData = init_line({mem2Addr[15:4], 4'b0000});

  always @(posedge clk) begin
    if (memWe) begin
      mem[memAddr[15:4]]      <= memWriteData;
      wr_valid[memAddr[15:4]] <= 1'b1;
    end
  end

  mem_arbiter #(.cache_line_width(LW), .addr_width(AW), .mem_latency(LAT)) dut (
    .clk(clk), .reset(reset),
    .iPetition(iPetition), .iAddr(iAddr), .iServiceReady(iServiceReady),
    .dPetition(dPetition), .dAddr(dAddr), .dWe(dWe), .dWriteData(dWriteData),
    .dServiceReady(dServiceReady), .dataReadFromMem(dataReadFromMem),
    .memAddr(memAddr), .memWe(memWe), .memWriteData(memWriteData),
    .memReadData(memReadData), .busy(busy)
  );

  mem_arbiter #(.cache_line_width(LW), .addr_width(AW), .mem_latency(1)) dut2 (
    .clk(clk), .reset(reset),
    .iPetition(i2Petition), .iAddr(i2Addr), .iServiceReady(i2ServiceReady),
    .dPetition(d2Petition), .dAddr(d2Addr), .dWe(d2We), .dWriteData(d2WriteData),
    .dServiceReady(d2ServiceReady), .dataReadFromMem(data2ReadFromMem),
    .memAddr(mem2Addr), .memWe(mem2We), .memWriteData(mem2WriteData),
    .memReadData(mem2ReadData), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the petition is visible (cycle 0); returns
  // in the IDLE cycle following RESP.
  task automatic svc(input string tag, input bit is_d, input logic [AW-1:0] a,
                     input bit we, input logic [LW-1:0] wd, input logic [LW-1:0] rd,
                     input bit clr);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == 1) dWriteData = {8{32'hBAD0_F00D}};
      chk({tag, "_addr"},  LW'(memAddr), LW'(a));
      chk({tag, "_busy"},  LW'(busy), 1);
      chk({tag, "_irdy"},  LW'(iServiceReady), LW'((k == LAT + 1) && !is_d));
      chk({tag, "_drdy"},  LW'(dServiceReady), LW'((k == LAT + 1) && is_d));
      chk({tag, "_we"},    LW'(memWe), LW'((k == LAT + 1) && we));
      if (k == LAT + 1) begin
        chk({tag, "_data"}, dataReadFromMem, rd);
        if (we) chk({tag, "_wdata"}, memWriteData, wd);
        if (clr) begin
          if (is_d) dPetition = 1'b0;
          else      iPetition = 1'b0;
        end
      end
    end
    tick();
    chk({tag, "_idle"},   LW'(busy), 0);
    chk({tag, "_irdy0"},  LW'(iServiceReady), 0);
    chk({tag, "_drdy0"},  LW'(dServiceReady), 0);
  endtask

  logic [LW-1:0] pat;

  initial begin
    reset = 1'b1;
    iPetition = 1'b0; dPetition = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWriteData = '0;
    i2Petition = 1'b0; i2Addr = '0;
    pat = {4{64'h0123_4567_89AB_CDEF}};

    tick(); tick();
    chk("rst_busy",  LW'(busy), 0);
    chk("rst_irdy",  LW'(iServiceReady), 0);
    chk("rst_drdy",  LW'(dServiceReady), 0);
    chk("rst_we",    LW'(memWe), 0);
    chk("rst_addr",  LW'(memAddr), 0);
    chk("rst_wdata", memWriteData, '0);
    reset = 1'b0;
    tick();

    // single instruction miss
    iPetition = 1'b1; iAddr = 16'h1235;
    svc("imiss", 1'b0, 16'h1230, 1'b0, '0, init_line(16'h1230), 1'b1);

    // reset in the middle of BUSY abandons the request
    iPetition = 1'b1; iAddr = 16'h4567;
    tick(); iPetition = 1'b0;
    tick(); tick();
    chk("abort_busy_pre", LW'(busy), 1);
    chk("abort_addr_pre", LW'(memAddr), LW'(16'h4560));
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", LW'(busy), 0);
    chk("abort_we",   LW'(memWe), 0);
    chk("abort_irdy", LW'(iServiceReady), 0);
    chk("abort_addr", LW'(memAddr), 0);
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_nopulse", LW'(iServiceReady), 0);
      chk("abort_idle",    LW'(busy), 0);
    end

    // simultaneous petitions: I first after reset, then D, then I again
    iPetition = 1'b1; iAddr = 16'h5555;
    dPetition = 1'b1; dAddr = 16'h6666;
    svc("both1_i", 1'b0, 16'h5550, 1'b0, '0, init_line(16'h5550), 1'b1);
    svc("both1_d", 1'b1, 16'h6660, 1'b0, '0, init_line(16'h6660), 1'b1);
    iPetition = 1'b1; iAddr = 16'h7071;
    dPetition = 1'b1; dAddr = 16'h8082;
    svc("both2_i", 1'b0, 16'h7070, 1'b0, '0, init_line(16'h7070), 1'b1);
    svc("both2_d", 1'b1, 16'h8080, 1'b0, '0, init_line(16'h8080), 1'b1);

    // data line write, then read back through the instruction side
    dPetition = 1'b1; dWe = 1'b1; dAddr = 16'h0047; dWriteData = pat;
    svc("dwrite", 1'b1, 16'h0040, 1'b1, pat, init_line(16'h0040), 1'b1);
    dWe = 1'b0;
    iPetition = 1'b1; iAddr = 16'h004F;
    svc("iread_back", 1'b0, 16'h0040, 1'b0, '0, pat, 1'b1);

    // D held continuously while I toggles: grants alternate
    dPetition = 1'b1; dAddr = 16'h2003;
    iPetition = 1'b1; iAddr = 16'h3004;
    svc("alt_d1", 1'b1, 16'h2000, 1'b0, '0, init_line(16'h2000), 1'b0);
    svc("alt_i1", 1'b0, 16'h3000, 1'b0, '0, init_line(16'h3000), 1'b1);
    svc("alt_d2", 1'b1, 16'h2000, 1'b0, '0, init_line(16'h2000), 1'b0);
    iPetition = 1'b1; iAddr = 16'h3108;
    svc("alt_i2", 1'b0, 16'h3100, 1'b0, '0, init_line(16'h3100), 1'b1);
    svc("alt_d3", 1'b1, 16'h2000, 1'b0, '0, init_line(16'h2000), 1'b1);

    // latency 1 instance, petition dropped while BUSY
    i2Petition = 1'b1; i2Addr = 16'h00AB;
    tick();
    chk("lat1_busy", LW'(busy2), 1);
    chk("lat1_addr", LW'(mem2Addr), LW'(16'h00A0));
    chk("lat1_rdy0", LW'(i2ServiceReady), 0);
    i2Petition = 1'b0;
    tick();
    chk("lat1_rdy",  LW'(i2ServiceReady), 1);
    chk("lat1_drdy", LW'(d2ServiceReady), 0);
    chk("lat1_data", data2ReadFromMem, init_line(16'h00A0));
    tick();
    chk("lat1_rdy_end",  LW'(i2ServiceReady), 0);
    chk("lat1_busy_end", LW'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
